// File: rtl/user_lock_write_arbiter.sv
// Round-robin write arbiter for the user-locked register: only OWNER_ID commits, others are denied.
// Optional violation counting and timed lockout are enabled by defining ULR_ARB_LOCKOUT_EN.
module user_lock_write_arbiter #(
  parameter int         DATA_W         = 8,
  parameter logic [1:0] OWNER_ID       = 2'h2,
  parameter int         VIOL_MAX       = 3,
  parameter int         LOCKOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          gnt,
  output logic [3:0]          deny,
  output logic                reg_wr_en,
  output logic [1:0]          reg_usr_id,
  output logic [DATA_W-1:0]   reg_data,
  output logic [DATA_W-1:0]   data_out,
  output logic                locked_out,
  output logic [1:0]          viol_cnt
);

  if (VIOL_MAX < 1 || VIOL_MAX > 3 || LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 256) begin : g_bad_cfg
    $error("user_lock_write_arbiter: VIOL_MAX must be 1..3 and LOCKOUT_CYCLES 1..256");
  end

`ifdef ULR_ARB_LOCKOUT_EN
  typedef enum logic [1:0] {IDLE, DECIDE, LOCKOUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DECIDE} state_t;
`endif

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          deny_q, deny_d;
  logic                wr_en_q, wr_en_d;
  logic [1:0]          usr_id_q, usr_id_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [3:0]          elig;
`ifdef ULR_ARB_LOCKOUT_EN
  logic [1:0]          viol_q, viol_d, viol_nxt;
  logic                locked_q, locked_d;
  logic [7:0]          lk_cnt_q, lk_cnt_d;
`endif

  // First eligible requester at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] el, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && el[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cap_d      = cap_q;
    gnt_d      = 4'b0;
    deny_d     = 4'b0;
    wr_en_d    = 1'b0;
    usr_id_d   = usr_id_q;
    reg_data_d = reg_data_q;
    data_out_d = data_out_q;
    // A requester whose pulse is showing this cycle is still holding req; ignore it once.
    elig       = req & ~gnt_q & ~deny_q;
`ifdef ULR_ARB_LOCKOUT_EN
    viol_d     = viol_q;
    viol_nxt   = (viol_q == 2'd3) ? 2'd3 : viol_q + 2'd1;
    locked_d   = locked_q;
    lk_cnt_d   = lk_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|elig) begin
          sel_d   = rr_pick(elig, ptr_q);
          cap_d   = wdata[int'(sel_d)*DATA_W +: DATA_W];
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        ptr_d   = sel_q + 2'd1;
        state_d = IDLE;
        if (sel_q == OWNER_ID) begin
          gnt_d[sel_q] = 1'b1;
          wr_en_d      = 1'b1;
          usr_id_d     = sel_q;
          reg_data_d   = cap_q;
          data_out_d   = cap_q;
        end else begin
          deny_d[sel_q] = 1'b1;
`ifdef ULR_ARB_LOCKOUT_EN
          viol_d = viol_nxt;
          if (viol_nxt == 2'(VIOL_MAX)) begin
            state_d  = LOCKOUT;
            locked_d = 1'b1;
            lk_cnt_d = 8'(LOCKOUT_CYCLES - 1);
          end
`endif
        end
      end
`ifdef ULR_ARB_LOCKOUT_EN
      LOCKOUT: begin
        if (lk_cnt_q == 8'd0) begin
          viol_d   = 2'd0;
          locked_d = 1'b0;
          state_d  = IDLE;
        end else begin
          lk_cnt_d = lk_cnt_q - 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_q      <= 4'b0;
      deny_q     <= 4'b0;
      wr_en_q    <= 1'b0;
      usr_id_q   <= 2'd0;
      reg_data_q <= '0;
      data_out_q <= '0;
`ifdef ULR_ARB_LOCKOUT_EN
      viol_q     <= 2'd0;
      locked_q   <= 1'b0;
      lk_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      deny_q     <= deny_d;
      wr_en_q    <= wr_en_d;
      usr_id_q   <= usr_id_d;
      reg_data_q <= reg_data_d;
      data_out_q <= data_out_d;
`ifdef ULR_ARB_LOCKOUT_EN
      viol_q     <= viol_d;
      locked_q   <= locked_d;
      lk_cnt_q   <= lk_cnt_d;
`endif
    end
  end

  // Selection and captured data are only consumed in DECIDE, so they need no reset.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    cap_q <= cap_d;
  end

  assign gnt        = gnt_q;
  assign deny       = deny_q;
  assign reg_wr_en  = wr_en_q;
  assign reg_usr_id = usr_id_q;
  assign reg_data   = reg_data_q;
  assign data_out   = data_out_q;
`ifdef ULR_ARB_LOCKOUT_EN
  assign locked_out = locked_q;
  assign viol_cnt   = viol_q;
`else
  assign locked_out = 1'b0;
  assign viol_cnt   = 2'd0;
`endif

endmodule

// File: tb/tb_user_lock_write_arbiter.sv
// Directed, table-driven bench for user_lock_write_arbiter; expectations adapt to ULR_ARB_LOCKOUT_EN.
module tb_user_lock_write_arbiter;

`ifdef ULR_ARB_LOCKOUT_EN
  localparam bit LK_ON = 1'b1;
`else
  localparam bit LK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt, deny;
  logic        reg_wr_en;
  logic [1:0]  reg_usr_id;
  logic [7:0]  reg_data, data_out;
  logic        locked_out;
  logic [1:0]  viol_cnt;

  user_lock_write_arbiter #(
    .DATA_W(8), .OWNER_ID(2'h2), .VIOL_MAX(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .deny(deny), .reg_wr_en(reg_wr_en), .reg_usr_id(reg_usr_id),
    .reg_data(reg_data), .data_out(data_out), .locked_out(locked_out), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic [3:0]  deny;
    logic        wr;
    logic [1:0]  id;
    logic [7:0]  rd;
    logic [7:0]  dout;
    logic        lk;
    logic [1:0]  vc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t v(input logic rst, input logic [3:0] rq, input logic [31:0] wd,
                             input logic [3:0] g, input logic [3:0] d, input logic wr,
                             input logic [1:0] id, input logic [7:0] rd, input logic [7:0] dout,
                             input logic lk_on, input logic [1:0] vc_on);
    vec_t r;
    r.rst = rst; r.req = rq; r.wd = wd; r.gnt = g; r.deny = d; r.wr = wr;
    r.id = id; r.rd = rd; r.dout = dout;
    r.lk = LK_ON ? lk_on : 1'b0;
    r.vc = LK_ON ? vc_on : 2'd0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {2'b0, gnt, deny, reg_wr_en, reg_usr_id, reg_data, data_out, locked_out, viol_cnt};
  endfunction

  localparam logic [31:0] W1 = 32'h443C2211;

  initial begin
    rst_n = 1'b1; req = 4'h0; wdata = 32'h0;
    //            rst  req   wdata          gnt   deny  wr  id  rd     dout   lk  vc
    tbl.push_back(v(1, 4'hF, 32'h0,         4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(1, 4'hF, 32'h0,         4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(0, 4'hF, W1,            4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(0, 4'hF, W1,            4'h0, 4'h1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd1));
    tbl.push_back(v(0, 4'hE, W1,            4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd1));
    tbl.push_back(v(0, 4'hE, W1,            4'h0, 4'h2, 0, 2'd0, 8'h00, 8'h00, 0, 2'd2));
    tbl.push_back(v(0, 4'hC, W1,            4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd2));
    tbl.push_back(v(0, 4'hC, W1,            4'h4, 4'h0, 1, 2'd2, 8'h3C, 8'h3C, 0, 2'd2));
    tbl.push_back(v(0, 4'h8, W1,            4'h0, 4'h0, 0, 2'd2, 8'h3C, 8'h3C, 0, 2'd2));
    tbl.push_back(v(0, 4'h8, W1,            4'h0, 4'h8, 0, 2'd2, 8'h3C, 8'h3C, 1, 2'd3));
    tbl.push_back(v(1, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(1, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    // owner write; wdata changes while deciding must not reach the register
    tbl.push_back(v(0, 4'h4, 32'h00A50000,  4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(0, 4'h4, 32'hFFFFFFFF,  4'h4, 4'h0, 1, 2'd2, 8'hA5, 8'hA5, 0, 2'd0));
    tbl.push_back(v(0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd2, 8'hA5, 8'hA5, 0, 2'd0));
    tbl.push_back(v(1, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    // reset while deciding discards the owner write
    tbl.push_back(v(0, 4'h4, 32'h00770000,  4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(1, 4'h4, 32'h00770000,  4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(0, 4'h0, 32'h00770000,  4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    // req dropped during the decision still completes it
    tbl.push_back(v(0, 4'h4, 32'h005A0000,  4'h0, 4'h0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0));
    tbl.push_back(v(0, 4'h0, 32'h0,         4'h4, 4'h0, 1, 2'd2, 8'h5A, 8'h5A, 0, 2'd0));
    tbl.push_back(v(0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd2, 8'h5A, 8'h5A, 0, 2'd0));
    // req held through its own pulse is ignored that cycle, then re-arbitrated
    tbl.push_back(v(0, 4'h4, 32'h00110000,  4'h0, 4'h0, 0, 2'd2, 8'h5A, 8'h5A, 0, 2'd0));
    tbl.push_back(v(0, 4'h4, 32'h00110000,  4'h4, 4'h0, 1, 2'd2, 8'h11, 8'h11, 0, 2'd0));
    tbl.push_back(v(0, 4'h4, 32'h00110000,  4'h0, 4'h0, 0, 2'd2, 8'h11, 8'h11, 0, 2'd0));
    tbl.push_back(v(0, 4'h4, 32'h00220000,  4'h0, 4'h0, 0, 2'd2, 8'h11, 8'h11, 0, 2'd0));
    tbl.push_back(v(0, 4'h4, 32'h00220000,  4'h4, 4'h0, 1, 2'd2, 8'h22, 8'h22, 0, 2'd0));
    tbl.push_back(v(0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 2'd2, 8'h22, 8'h22, 0, 2'd0));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst;
      req   = tbl[i].req;
      wdata = tbl[i].wd;
      tick();
      chk($sformatf("row%0d", i), outs(),
          {2'b0, tbl[i].gnt, tbl[i].deny, tbl[i].wr, tbl[i].id, tbl[i].rd,
           tbl[i].dout, tbl[i].lk, tbl[i].vc});
    end

`ifdef ULR_ARB_LOCKOUT_EN
    begin : lockout_seq
      int hi;
      int n;
      int bad;
      wdata = 32'h00C70000;
      for (int k = 1; k <= 3; k++) begin
        req = 4'h2;
        tick();
        tick();
        chk($sformatf("viol_deny%0d", k), {25'b0, deny, locked_out, viol_cnt},
            {25'b0, 4'h2, (k == 3), 2'(k)});
        req = (k == 3) ? 4'h4 : 4'h0;
        if (k != 3) tick();
      end
      hi = 1; n = 0; bad = 0;
      while (locked_out && n < 40) begin
        tick();
        n++;
        if (locked_out) hi++;
        if ((gnt | deny) != 4'h0 || reg_wr_en) bad++;
      end
      chk("lockout_len", hi, 16);
      chk("lockout_quiet", bad, 0);
      chk("lockout_exit_viol", {30'b0, viol_cnt}, 0);
      tick();
      chk("post_lock_decide", {28'b0, gnt}, 0);
      tick();
      chk("post_lock_gnt", {13'b0, gnt, reg_wr_en, reg_usr_id, data_out, viol_cnt},
          {13'b0, 4'h4, 1'b1, 2'd2, 8'hC7, 2'd0});
      req = 4'h0;
      tick();
    end
`else
    begin : no_lock_seq
      int npulse;
      int bad;
      npulse = 0; bad = 0;
      for (int k = 0; k < 4; k++) begin
        req = 4'h8;
        wdata = 32'h99000000;
        tick();
        if (locked_out || viol_cnt != 2'd0) bad++;
        tick();
        if (deny == 4'h8 && gnt == 4'h0 && !reg_wr_en) npulse++;
        if (locked_out || viol_cnt != 2'd0) bad++;
        req = 4'h0;
        tick();
        if (locked_out || viol_cnt != 2'd0 || deny != 4'h0) bad++;
      end
      chk("u3_deny_pulses", npulse, 4);
      chk("u3_no_lock", bad, 0);
      chk("u3_data_kept", {24'b0, data_out}, 32'h22);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/user_lock_write_arbiter.md
# user_lock_write_arbiter

Round-robin write arbiter and access controller for the user-locked 8-bit register. Collects write requests from four user IDs, selects one per decision slot, commits the data only when the winner is the owner ID, and denies everyone else. Optionally counts denied writes and enters a timed lockout after repeated violations. Sits between the bus-side requesters and the user-locked register write port.

## Interface
- DATA_W, 8: register data width
- OWNER_ID, 2'h2: only user ID allowed to commit writes
- VIOL_MAX, 3: denied writes that trigger lockout (1..3)
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (>=1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-high (rst_n=1 resets on the clk edge)
- req  in  4  per-user write request, bit i = user ID i; level, held until gnt[i] or deny[i]
- wdata  in  4*DATA_W  packed write data, user i at [i*DATA_W +: DATA_W]
- gnt  out  4  one-hot, one-cycle pulse: write committed
- deny  out  4  one-hot, one-cycle pulse: write rejected
- reg_wr_en  out  1  one-cycle write strobe to the locked register
- reg_usr_id  out  2  user ID presented with the strobe
- reg_data  out  DATA_W  data presented with the strobe
- data_out  out  DATA_W  shadow of last committed value
- locked_out  out  1  high while in LOCKOUT
- viol_cnt  out  2  current violation count

## Operation
- States: IDLE, DECIDE, LOCKOUT. All outputs registered.
- IDLE: eligible = req & ~gnt & ~deny (a requester whose pulse is high this cycle is ignored). If eligible != 0, pick the first set bit searching ptr, ptr+1, ... mod 4; capture sel and wdata[sel]; go DECIDE. Otherwise stay IDLE.
- DECIDE, sel == OWNER_ID: next edge sets gnt[sel]=1, reg_wr_en=1, reg_usr_id=sel, reg_data=captured data, data_out=captured data.
- DECIDE, sel != OWNER_ID: next edge sets deny[sel]=1, viol_cnt+1 (saturating at 3); no strobe, data_out unchanged.
- After DECIDE: ptr = (sel+1) mod 4. Next state is LOCKOUT if the updated viol_cnt == VIOL_MAX, else IDLE.
- LOCKOUT: locked_out=1, no gnt/deny/strobe, requests stay pending. 8-bit down-counter loaded with LOCKOUT_CYCLES-1 on entry; at zero, clear viol_cnt and locked_out, go IDLE.
- Granted writes do not clear viol_cnt; only lockout exit and reset do.
- gnt, deny, reg_wr_en are zero in every cycle except the one after DECIDE.

## Timing
- Reset: state IDLE, ptr=0, viol_cnt=0, locked_out=0, gnt=deny=0, reg_wr_en=0, reg_usr_id=0, reg_data=0, data_out=0, lockout counter=0.
- req high at edge E0 (IDLE) -> gnt/deny and reg_wr_en high for exactly the cycle after E1; data_out valid after E1.
- Throughput: one decision per 2 cycles; a new arbitration can be sampled at E2.
- A requester drops req in the cycle its gnt/deny is high. If req is still high at the next edge, it is treated as a new request.
- wdata is sampled only at the IDLE->DECIDE edge; changes during DECIDE are ignored.
- Lockout entry: the deny pulse and locked_out=1 appear after the same edge. locked_out stays high exactly LOCKOUT_CYCLES cycles.
- Reset asserted in DECIDE or LOCKOUT discards the pending decision: no gnt/deny is emitted, all reset values apply after the edge.
- req deasserted while in DECIDE: the decision still completes.

## Configuration
- ULR_ARB_LOCKOUT_EN defined: violation counting and the LOCKOUT state behave as above.
- Not defined: the LOCKOUT state, lockout counter and violation counter are removed. viol_cnt and locked_out are tied to 0, VIOL_MAX and LOCKOUT_CYCLES are unused, and denial pulses are still generated.

## Test plan
- Reset: hold rst_n=1 for 2 cycles with req=4'hF -> every output 0, no pulses. Release reset -> first decision goes to user 0 (deny[0]) because ptr=0.
- Owner write: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100, reg_wr_en=1, reg_usr_id=2, reg_data=8'hA5 exactly 2 cycles later; data_out=8'hA5 afterwards.
- Round-robin: req=4'hF held, each requester dropping its req on its own pulse -> pulse order deny[0], deny[1], gnt[2], deny[3] with wdata[2]=8'h3C; then data_out=8'h3C; with ULR_ARB_LOCKOUT_EN, viol_cnt reaches 3 on deny[3], which also triggers lockout.
- Lockout (macro on): user 1 issues three requests -> third deny coincides with locked_out=1. Owner req during lockout is held off 16 cycles, then granted; viol_cnt=0 at exit.
- Reset mid-operation: assert rst_n during DECIDE of an owner write with wdata=8'h77 -> no gnt, data_out stays 0.
- Macro off: user 3 issues four requests -> four deny[3] pulses, locked_out and viol_cnt always 0.
